mips_multicycle_ctrl: RTL and testbench



---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/mips_multicycle_ctrl_alu_funct_decode.sv | 25 ++
 rtl/mips_multicycle_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its ALU: ALU ops,
// opcode/funct values, FSM states and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_NOP = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
    } state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_funct_decode.sv
// R-type funct field to ALU operation, with a legal flag for unknown functs.
// Purely combinational; no backpressure.
module alu_funct_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_NOP;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM driving ALU op, datapath muxes and enables.
// 3-5 cycles per instruction; stalls in FETCH/MEM_RD/MEM_WR until mem_ready.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       alu_positive,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_instr
);

    state_t     state, next_state;
    logic       set_illegal;
    logic [3:0] r_alu_op;
    logic       r_legal;

    alu_funct_decode u_funct_decode (
        .funct  (funct),
        .alu_op (r_alu_op),
        .legal  (r_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            illegal_instr <= 1'b0;
        end else begin
            state <= next_state;
            if (set_illegal)
                illegal_instr <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        alu_op      = ALU_NOP;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        imm_zext    = 1'b0;
        pc_source   = PCSRC_ALU;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;

        case (state)
            S_IDLE: next_state = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                pc_source = PCSRC_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    next_state = S_DECODE;
                end
            end

            // ALU computes PC + (sext imm << 2) here so BRANCH can take ALU-out.
            S_DECODE: begin
                alu_src_b = SRCB_BOFF;
                alu_op    = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_ADDI, OP_ORI:  next_state = S_I_EXEC;
                    OP_BEQ, OP_BGTZ:  next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    OP_RTYPE: begin
                        if (r_legal) begin
                            next_state = S_R_EXEC;
                        end else begin
                            set_illegal = 1'b1;
                            next_state  = S_FETCH;
                        end
                    end
                    default: begin
                        set_illegal = 1'b1;
                        next_state  = S_FETCH;
                    end
                endcase
            end

            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                next_state = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end

            S_MEM_RD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)
                    next_state = S_MEM_WB;
            end

            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = S_FETCH;
            end

            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready)
                    next_state = S_FETCH;
            end

            S_R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_REG;
                alu_op     = r_alu_op;
                next_state = S_R_WB;
            end

            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = S_FETCH;
            end

            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                if (op == OP_ORI) begin
                    alu_op   = ALU_OR;
                    imm_zext = 1'b1;
                end else begin
                    alu_op = ALU_ADD;
                end
                next_state = S_I_WB;
            end

            S_I_WB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end

            // bgtz passes A through (NOP) so alu_positive reflects rs > 0.
            S_BRANCH: begin
                alu_src_a = 1'b1;
                pc_source = PCSRC_ALUOUT;
                if (op == OP_BGTZ) begin
                    alu_op = ALU_NOP;
                    pc_en  = alu_positive;
                end else begin
                    alu_src_b = SRCB_REG;
                    alu_op    = ALU_SUB;
                    pc_en     = alu_zero;
                end
                next_state = S_FETCH;
            end

            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_en      = 1'b1;
                next_state = S_FETCH;
            end

            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: the driver queues expected per-cycle
// outputs, a negedge monitor pops and compares them.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       alu_zero, alu_positive, mem_ready;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_source;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal_instr;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       imm_zext;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  act;
    int    checks = 0;
    int    failures = 0;
    logic  exp_ill = 1'b0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .alu_zero(alu_zero), .alu_positive(alu_positive), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .pc_source(pc_source), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal_instr(illegal_instr)
    );

    always_comb act = {alu_op, alu_src_a, alu_src_b, imm_zext, pc_source, pc_en, iord,
                       mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                       illegal_instr};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s got=%05h exp=%05h", nm, act, e);
            end
        end
    end

    task automatic check(input string nm, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s", nm);
        end
    endtask

    // Expected outputs per state, written out from the state/output table.
    function automatic exp_t e_idle();
        exp_t e = '0;
        e.alu_op = 4'b1111;
        return e;
    endfunction
    function automatic exp_t e_fetch(logic rdy);
        exp_t e = e_idle();
        e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 4'b0010;
        e.ir_write = rdy;  e.pc_en = rdy;
        return e;
    endfunction
    function automatic exp_t e_decode();
        exp_t e = e_idle();
        e.alu_src_b = 2'b11; e.alu_op = 4'b0010;
        return e;
    endfunction
    function automatic exp_t e_exec(logic [1:0] srcb, logic [3:0] aop, logic zext);
        exp_t e = e_idle();
        e.alu_src_a = 1'b1; e.alu_src_b = srcb; e.alu_op = aop; e.imm_zext = zext;
        return e;
    endfunction
    function automatic exp_t e_mem(logic wr);
        exp_t e = e_idle();
        e.iord = 1'b1; e.mem_read = ~wr; e.mem_write = wr;
        return e;
    endfunction
    function automatic exp_t e_wb(logic dst, logic m2r);
        exp_t e = e_idle();
        e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
        return e;
    endfunction
    function automatic exp_t e_branch(logic [3:0] aop, logic taken);
        exp_t e = e_idle();
        e.alu_src_a = 1'b1; e.pc_source = 2'b01; e.alu_op = aop; e.pc_en = taken;
        return e;
    endfunction
    function automatic exp_t e_jump();
        exp_t e = e_idle();
        e.pc_source = 2'b10; e.pc_en = 1'b1;
        return e;
    endfunction

    task automatic cyc(input string nm, input logic rdy, input logic z, input logic p,
                       input logic rst, input exp_t e);
        exp_t ee = e;
        mem_ready = rdy; alu_zero = z; alu_positive = p; rst_n = rst;
        ee.illegal = exp_ill;
        exp_q.push_back(ee);
        name_q.push_back(nm);
        @(posedge clk); #1;
    endtask

    task automatic run_r(input logic [5:0] f, input logic [3:0] aop);
        op = 6'h00; funct = f;
        cyc("r_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("r_decode", 0, 1, 1, 1, e_decode());
        cyc("r_exec", 0, 0, 0, 1, e_exec(2'b00, aop, 0));
        cyc("r_wb", 0, 0, 0, 1, e_wb(1, 0));
    endtask

    logic [5:0] fn_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0] op_tab [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

    initial begin
        rst_n = 1'b0; op = '0; funct = '0;
        alu_zero = 1'b0; alu_positive = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        cyc("rst_hold", 0, 0, 0, 0, e_idle());
        check("reset_state_idle", act === e_idle());
        cyc("rst_rel_idle", 1, 0, 0, 1, e_idle());

        // R-type ALU ops, including add
        for (int i = 0; i < 6; i++) run_r(fn_tab[i], op_tab[i]);

        // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles
        op = 6'h23;
        cyc("lw_fetch_w0", 0, 0, 0, 1, e_fetch(0));
        cyc("lw_fetch_w1", 0, 0, 0, 1, e_fetch(0));
        cyc("lw_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("lw_decode", 1, 0, 0, 1, e_decode());
        cyc("lw_addr", 0, 0, 0, 1, e_exec(2'b10, 4'b0010, 0));
        cyc("lw_rd_w0", 0, 0, 0, 1, e_mem(0));
        cyc("lw_rd_w1", 0, 0, 0, 1, e_mem(0));
        cyc("lw_rd", 1, 0, 0, 1, e_mem(0));
        cyc("lw_wb", 0, 0, 0, 1, e_wb(0, 1));

        // sw zero wait
        op = 6'h2B;
        cyc("sw_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("sw_decode", 0, 0, 0, 1, e_decode());
        cyc("sw_addr", 0, 0, 0, 1, e_exec(2'b10, 4'b0010, 0));
        cyc("sw_wr", 1, 0, 0, 1, e_mem(1));

        // addi then ori
        op = 6'h08;
        cyc("addi_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("addi_decode", 0, 0, 0, 1, e_decode());
        cyc("addi_exec", 0, 0, 0, 1, e_exec(2'b10, 4'b0010, 0));
        cyc("addi_wb", 0, 0, 0, 1, e_wb(0, 0));
        op = 6'h0D;
        cyc("ori_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("ori_decode", 0, 0, 0, 1, e_decode());
        cyc("ori_exec", 0, 0, 0, 1, e_exec(2'b10, 4'b0001, 1));
        cyc("ori_wb", 0, 0, 0, 1, e_wb(0, 0));

        // beq taken / not taken, bgtz taken / not taken, j
        op = 6'h04;
        cyc("beq1_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("beq1_decode", 0, 0, 0, 1, e_decode());
        cyc("beq1_branch", 0, 1, 0, 1, e_branch(4'b0110, 1));
        cyc("beq0_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("beq0_decode", 0, 0, 0, 1, e_decode());
        cyc("beq0_branch", 1, 0, 1, 1, e_branch(4'b0110, 0));
        op = 6'h07;
        cyc("bgtz1_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("bgtz1_decode", 0, 0, 0, 1, e_decode());
        cyc("bgtz1_branch", 0, 0, 1, 1, e_branch(4'b1111, 1));
        cyc("bgtz0_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("bgtz0_decode", 0, 0, 0, 1, e_decode());
        cyc("bgtz0_branch", 0, 1, 0, 1, e_branch(4'b1111, 0));
        op = 6'h02;
        cyc("j_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("j_decode", 0, 0, 0, 1, e_decode());
        cyc("j_jump", 0, 0, 0, 1, e_jump());

        // illegal op, then illegal funct; flag is sticky
        op = 6'h3F;
        cyc("ill_op_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("ill_op_decode", 0, 0, 0, 1, e_decode());
        exp_ill = 1'b1;
        op = 6'h00; funct = 6'h01;
        cyc("ill_fn_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("ill_fn_decode", 0, 0, 0, 1, e_decode());
        run_r(6'h20, 4'b0010);

        // reset mid MEM_RD while memory is stalled
        op = 6'h23;
        cyc("rlw_fetch", 1, 0, 0, 1, e_fetch(1));
        cyc("rlw_decode", 0, 0, 0, 1, e_decode());
        cyc("rlw_addr", 0, 0, 0, 1, e_exec(2'b10, 4'b0010, 0));
        cyc("rlw_rd_rst", 0, 0, 0, 0, e_mem(0));
        check("reset_mid_mem_rd_idle", act === e_idle() && illegal_instr === 1'b0
                                       && mem_read === 1'b0 && mem_write === 1'b0);
        exp_ill = 1'b0;
        cyc("rst_idle", 0, 0, 0, 1, e_idle());
        cyc("rst_fetch", 0, 0, 0, 1, e_fetch(0));
        cyc("rst_fetch_go", 1, 0, 0, 1, e_fetch(1));
        cyc("rst_decode", 0, 0, 0, 1, e_decode());

        for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        check("expected_queue_drained_before_wait_expired", exp_q.size() == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
